// File: rtl/gpio_irq.sv
// rtl/gpio_irq.sv - 16-bit memory-mapped GPIO with per-pin edge interrupts
//
// Purpose: synchronises pin inputs, provides a read/write output register,
// and latches rising/falling pin events into software-cleared pending bits
// that drive a level interrupt.
//
// Ports:
//   clk, rstn          clock (rising edge), asynchronous active-low reset
//   req, gnt           bus request (pre-decoded) and zero-wait grant
//   we, be, addr       write enable, byte enables, byte offset (addr[4:2] = reg)
//   wdata, rdata       write data, registered read data
//   rvalid             one-cycle response strobe per accepted request
//   in, out            asynchronous pin inputs, pin outputs (OUT register)
//   irq                level interrupt, |(IRQ_PEND & IRQ_EN)

module gpio_irq (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req,
  output logic        gnt,
  output logic        rvalid,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [15:0] in,
  output logic [15:0] out,
  output logic        irq
);

  localparam logic [2:0] REG_IN   = 3'd0;
  localparam logic [2:0] REG_OUT  = 3'd1;
  localparam logic [2:0] REG_EN   = 3'd2;
  localparam logic [2:0] REG_RISE = 3'd3;
  localparam logic [2:0] REG_FALL = 3'd4;
  localparam logic [2:0] REG_PEND = 3'd5;

  logic [15:0] s1, s2, s3;
  logic [15:0] out_q, en_q, rise_q, fall_q, pend_q;

  logic [2:0]  sel;
  logic        wr;
  logic [15:0] lane_mask;
  logic [15:0] ev;
  logic [15:0] clr;
  logic [15:0] rd_val;

  // Upper data bits, upper byte enables and the sub-word offset carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{wdata[31:16], be[3:2], addr[1:0]};

  assign gnt       = req;
  assign sel       = addr[4:2];
  assign wr        = req & we;
  assign lane_mask = {{8{be[1]}}, {8{be[0]}}};

  assign ev  = (s2 & ~s3 & rise_q) | (~s2 & s3 & fall_q);
  assign clr = (wr && sel == REG_PEND) ? (wdata[15:0] & lane_mask) : 16'h0000;

  assign out = out_q;
  assign irq = |(pend_q & en_q);

  always_comb begin
    rd_val = 16'h0000;
    case (sel)
      REG_IN:   rd_val = s2;
      REG_OUT:  rd_val = out_q;
      REG_EN:   rd_val = en_q;
      REG_RISE: rd_val = rise_q;
      REG_FALL: rd_val = fall_q;
      REG_PEND: rd_val = pend_q;
      default:  rd_val = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1     <= '0;
      s2     <= '0;
      s3     <= '0;
      out_q  <= '0;
      en_q   <= '0;
      rise_q <= '0;
      fall_q <= '0;
      pend_q <= '0;
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      s1 <= in;
      s2 <= s1;
      s3 <= s2;

      // A new event wins over a simultaneous software clear so no edge is lost.
      pend_q <= ev | (pend_q & ~clr);

      if (wr) begin
        case (sel)
          REG_OUT:  out_q  <= (out_q  & ~lane_mask) | (wdata[15:0] & lane_mask);
          REG_EN:   en_q   <= (en_q   & ~lane_mask) | (wdata[15:0] & lane_mask);
          REG_RISE: rise_q <= (rise_q & ~lane_mask) | (wdata[15:0] & lane_mask);
          REG_FALL: fall_q <= (fall_q & ~lane_mask) | (wdata[15:0] & lane_mask);
          default:  ;
        endcase
      end

      rvalid <= req;
      if (req) begin
        rdata <= we ? 32'h0 : {16'h0000, rd_val};
      end
    end
  end

endmodule

// File: tb/tb_gpio_irq.sv
// tb/tb_gpio_irq.sv - directed self-checking bench for gpio_irq

module tb_gpio_irq;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req;
  logic        gnt;
  logic        rvalid;
  logic        we;
  logic [3:0]  be;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [15:0] in;
  logic [15:0] out;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gpio_irq dut (
    .clk    (clk),
    .rstn   (rstn),
    .req    (req),
    .gnt    (gnt),
    .rvalid (rvalid),
    .we     (we),
    .be     (be),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .in     (in),
    .out    (out),
    .irq    (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus transaction: drive at negedge, accept at next posedge, check response 1 ns later.
  task automatic bus(input logic w, input logic [3:0] b, input logic [4:0] a,
                     input logic [31:0] d, input logic [31:0] exp_rdata, input string tag);
    @(negedge clk);
    req = 1'b1; we = w; be = b; addr = a; wdata = d;
    #1 chk({tag, "_gnt"}, {31'h0, gnt}, 32'h1);
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'b0;
    chk({tag, "_rvalid"}, {31'h0, rvalid}, 32'h1);
    chk({tag, "_rdata"}, rdata, exp_rdata);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; req = 1'b0; we = 1'b0; be = 4'h0; addr = 5'h0; wdata = 32'h0;
    in = 16'hFFFF;
    cycles(3);
    chk("rst_rvalid", {31'h0, rvalid}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_out", {16'h0, out}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    @(negedge clk) rstn = 1'b1;
    cycles(3);

    // Reset state and input path
    bus(1'b0, 4'hF, 5'h00, 32'h0, 32'h0000FFFF, "rd_in");
    chk("irq_after_rst", {31'h0, irq}, 32'h0);
    bus(1'b0, 4'hF, 5'h14, 32'h0, 32'h0, "rd_pend0");
    bus(1'b0, 4'hF, 5'h1C, 32'h0, 32'h0, "rd_reg7");

    // OUT byte-lane writes
    bus(1'b1, 4'b0001, 5'h04, 32'hDEADBEEF, 32'h0, "wr_out_b0");
    chk("out_b0", {16'h0, out}, 32'h000000EF);
    bus(1'b1, 4'b0010, 5'h04, 32'hDEADBEEF, 32'h0, "wr_out_b1");
    chk("out_b1", {16'h0, out}, 32'h0000BEEF);
    bus(1'b0, 4'hF, 5'h04, 32'h0, 32'h0000BEEF, "rd_out");
    bus(1'b1, 4'b1100, 5'h04, 32'h12345678, 32'h0, "wr_out_hi");
    chk("out_hi_ignored", {16'h0, out}, 32'h0000BEEF);

    // Rising edge on in[2]
    bus(1'b1, 4'b0011, 5'h0C, 32'h00000004, 32'h0, "wr_rise");
    bus(1'b1, 4'b0011, 5'h08, 32'h00000004, 32'h0, "wr_en");
    @(negedge clk) in[2] = 1'b0;
    cycles(4);
    bus(1'b0, 4'hF, 5'h14, 32'h0, 32'h0, "rd_pend_nofall");
    @(negedge clk) in[2] = 1'b1;
    @(posedge clk);              // edge k
    @(posedge clk); #1;          // edge k+1
    chk("irq_k1", {31'h0, irq}, 32'h0);
    @(posedge clk); #1;          // edge k+2
    chk("irq_k2", {31'h0, irq}, 32'h1);
    bus(1'b0, 4'hF, 5'h14, 32'h0, 32'h00000004, "rd_pend_rise");
    bus(1'b1, 4'b0001, 5'h14, 32'h00000004, 32'h0, "w1c_bit2");
    chk("irq_w1c", {31'h0, irq}, 32'h0);

    // Falling edge on in[9], enable masked
    bus(1'b1, 4'b0011, 5'h08, 32'h0, 32'h0, "wr_en0");
    bus(1'b1, 4'b0010, 5'h10, 32'h00000200, 32'h0, "wr_fall");
    @(negedge clk) in[9] = 1'b0;
    cycles(3);
    bus(1'b0, 4'hF, 5'h14, 32'h0, 32'h00000200, "rd_pend_fall");
    chk("irq_masked", {31'h0, irq}, 32'h0);
    bus(1'b1, 4'b0010, 5'h08, 32'h00000200, 32'h0, "wr_en9");
    chk("irq_en9", {31'h0, irq}, 32'h1);
    bus(1'b1, 4'b0001, 5'h14, 32'h00000200, 32'h0, "w1c_wrong_lane");
    bus(1'b0, 4'hF, 5'h14, 32'h0, 32'h00000200, "rd_pend_kept");
    bus(1'b1, 4'b0010, 5'h14, 32'h00000200, 32'h0, "w1c_bit9");
    chk("irq_bit9_clr", {31'h0, irq}, 32'h0);

    // Event has priority over a same-edge clear
    bus(1'b1, 4'b0011, 5'h08, 32'h00000204, 32'h0, "wr_en_2_9");
    @(negedge clk) in[2] = 1'b0;
    cycles(4);
    chk("irq_pre_race", {31'h0, irq}, 32'h0);
    @(negedge clk) in[2] = 1'b1;
    @(posedge clk);              // edge k
    @(posedge clk);              // edge k+1
    @(negedge clk);
    req = 1'b1; we = 1'b1; be = 4'b0001; addr = 5'h14; wdata = 32'h00000004;
    @(posedge clk); #1;          // edge k+2: event and clear coincide
    req = 1'b0; we = 1'b0;
    chk("race_rvalid", {31'h0, rvalid}, 32'h1);
    chk("race_irq", {31'h0, irq}, 32'h1);
    bus(1'b0, 4'hF, 5'h14, 32'h0, 32'h00000004, "rd_pend_race");

    // Back-to-back reads, reset before the third response
    @(negedge clk);
    req = 1'b1; we = 1'b0; be = 4'hF; addr = 5'h00;
    @(posedge clk); #1;
    chk("b2b0_gnt", {31'h0, gnt}, 32'h1);
    chk("b2b0_rvalid", {31'h0, rvalid}, 32'h1);
    chk("b2b0_rdata", rdata, 32'h0000FDFF);
    addr = 5'h04;
    @(posedge clk); #1;
    chk("b2b1_gnt", {31'h0, gnt}, 32'h1);
    chk("b2b1_rvalid", {31'h0, rvalid}, 32'h1);
    chk("b2b1_rdata", rdata, 32'h0000BEEF);
    addr = 5'h08;
    @(negedge clk) rstn = 1'b0;
    #1;
    chk("b2b_rst_rvalid", {31'h0, rvalid}, 32'h0);
    chk("b2b_rst_rdata", rdata, 32'h0);
    chk("b2b_rst_gnt", {31'h0, gnt}, 32'h1);
    chk("b2b_rst_irq", {31'h0, irq}, 32'h0);
    addr = 5'h0C;
    @(posedge clk); #1;
    chk("b2b_rst_rvalid2", {31'h0, rvalid}, 32'h0);
    @(negedge clk);
    req = 1'b0;
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_rvalid", {31'h0, rvalid}, 32'h0);
    chk("post_rst_out", {16'h0, out}, 32'h0);
    bus(1'b0, 4'hF, 5'h08, 32'h0, 32'h0, "rd_en_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
